// File: rtl/pad_func_ctrl_cfg_if.sv
`default_nettype none
// ============================================================================
// Module      : pad_func_ctrl_cfg_if
// Description : Reconfiguration request port of the pad function controller.
//               The requester (master) holds cfg_valid_i with a pad/function
//               pair until cfg_ready_o is high. The controller (slave) answers
//               each request with a one-cycle cfg_done_o pulse, and raises
//               cfg_err_o in the same cycle when it rejects the request.
// Revision    : 1.0 - initial release
// ============================================================================
interface pad_func_ctrl_cfg_if #(
    parameter int PAD_W  = 5,
    parameter int FUNC_W = 2
);
    logic              cfg_valid_i;
    logic              cfg_ready_o;
    logic [PAD_W-1:0]  cfg_pad_i;
    logic [FUNC_W-1:0] cfg_func_i;
    logic              cfg_done_o;
    logic              cfg_err_o;

    modport master (
        output cfg_valid_i, cfg_pad_i, cfg_func_i,
        input  cfg_ready_o, cfg_done_o, cfg_err_o
    );

    modport slave (
        input  cfg_valid_i, cfg_pad_i, cfg_func_i,
        output cfg_ready_o, cfg_done_o, cfg_err_o
    );
endinterface
`default_nettype wire

// File: rtl/pad_func_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pad_func_ctrl
// Description : Time-shares each bidirectional pad between several peripheral
//               functions. A function change holds the target pad's driver
//               off for GUARD_CYCLES cycles (break-before-make) before the new
//               selection is committed. The last function slot is "parked"
//               and never drives its pad.
// Revision    : 1.0 - initial release
// ============================================================================
module pad_func_ctrl #(
    parameter int NUM_PADS     = 24,
    parameter int NUM_FUNCS    = 4,
    parameter int GUARD_CYCLES = 4
) (
    input  wire logic                              clk_i,
    input  wire logic                              rst_i,
    pad_func_ctrl_cfg_if.slave                     cfg,
    input  wire logic [NUM_FUNCS*NUM_PADS-1:0]     func_o_i,
    input  wire logic [NUM_FUNCS*NUM_PADS-1:0]     func_oe_i,
    output logic      [NUM_FUNCS*NUM_PADS-1:0]     func_i_o,
    output logic      [NUM_PADS-1:0]               pad_o_o,
    output logic      [NUM_PADS-1:0]               pad_oe_o,
    input  wire logic [NUM_PADS-1:0]               pad_i_i,
    output logic      [NUM_PADS*((NUM_FUNCS > 1) ? $clog2(NUM_FUNCS) : 1)-1:0] sel_o
);

    localparam int c_PAD_W  = (NUM_PADS > 1)     ? $clog2(NUM_PADS)     : 1;
    localparam int c_FUNC_W = (NUM_FUNCS > 1)    ? $clog2(NUM_FUNCS)    : 1;
    localparam int c_CNT_W  = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GUARD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_FUNC_W-1:0] r_sel [NUM_PADS];
    logic [c_PAD_W-1:0]  r_tgt_pad;
    logic [c_PAD_W-1:0]  w_tgt_pad_nxt;
    logic [c_FUNC_W-1:0] r_tgt_func;
    logic [c_FUNC_W-1:0] w_tgt_func_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                r_done;
    logic                r_err;
    logic                w_done_nxt;
    logic                w_err_nxt;
    logic                w_commit;
    logic                w_xfer;
    logic                w_req_bad;
    logic [c_FUNC_W-1:0] w_cur_sel;

    assign cfg.cfg_ready_o = (r_state == S_IDLE);
    assign cfg.cfg_done_o  = r_done;
    assign cfg.cfg_err_o   = r_err;

    // Requests are only consumed while idle; valid is ignored during a guard.
    assign w_xfer    = cfg.cfg_valid_i && (r_state == S_IDLE);
    assign w_req_bad = (int'(cfg.cfg_pad_i) >= NUM_PADS) || (int'(cfg.cfg_func_i) >= NUM_FUNCS);

    // Current selection of the requested pad (0 when the index is out of range).
    always_comb begin
        w_cur_sel = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (int'(cfg.cfg_pad_i) == p) begin
                w_cur_sel = r_sel[p];
            end
        end
    end

    // Next-state logic: accept/reject requests, count the guard, commit.
    always_comb begin
        w_state_nxt    = r_state;
        w_tgt_pad_nxt  = r_tgt_pad;
        w_tgt_func_nxt = r_tgt_func;
        w_cnt_nxt      = r_cnt;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_commit       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (w_req_bad) begin
                        w_done_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end else if (cfg.cfg_func_i == w_cur_sel) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_tgt_pad_nxt  = cfg.cfg_pad_i;
                        w_tgt_func_nxt = cfg.cfg_func_i;
                        w_cnt_nxt      = c_CNT_W'(GUARD_CYCLES - 1);
                        w_state_nxt    = S_GUARD;
                    end
                end
            end
            S_GUARD: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_commit    = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control registers; reset discards any pending change without a done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_tgt_pad  <= '0;
            r_tgt_func <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tgt_pad  <= w_tgt_pad_nxt;
            r_tgt_func <= w_tgt_func_nxt;
            r_cnt      <= w_cnt_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Per-pad selection registers; only the target pad changes, at commit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                r_sel[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PADS; p++) begin
                if (w_commit && (int'(r_tgt_pad) == p)) begin
                    r_sel[p] <= r_tgt_func;
                end
            end
        end
    end

    // Output and input routing; the guarded pad and parked pads never drive,
    // while inputs keep following the old selection until commit.
    always_comb begin
        pad_o_o  = '0;
        pad_oe_o = '0;
        func_i_o = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            for (int f = 0; f < NUM_FUNCS; f++) begin
                if (int'(r_sel[p]) == f) begin
                    func_i_o[f*NUM_PADS+p] = pad_i_i[p];
                    if ((f != NUM_FUNCS - 1) &&
                        !((r_state == S_GUARD) && (int'(r_tgt_pad) == p))) begin
                        pad_o_o[p]  = func_o_i[f*NUM_PADS+p];
                        pad_oe_o[p] = func_oe_i[f*NUM_PADS+p];
                    end
                end
            end
        end
    end

    // Flat view of the selection registers, pad 0 in the low bits.
    for (genvar gp = 0; gp < NUM_PADS; gp++) begin : g_sel
        assign sel_o[gp*c_FUNC_W +: c_FUNC_W] = r_sel[gp];
    end

endmodule
`default_nettype wire

// File: tb/tb_pad_func_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pad_func_ctrl
// Description : Directed, table-driven bench for pad_func_ctrl with a small
//               reference model of the per-pad selection and guard window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pad_func_ctrl;

    localparam int c_NP = 24;
    localparam int c_NF = 4;
    localparam int c_G  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [c_NF*c_NP-1:0] func_o;
    logic [c_NF*c_NP-1:0] func_oe;
    logic [c_NF*c_NP-1:0] func_i;
    logic [c_NP-1:0]      pad_o;
    logic [c_NP-1:0]      pad_oe;
    logic [c_NP-1:0]      pad_i;
    logic [c_NP*2-1:0]    sel;

    int n_checks = 0;
    int n_errors = 0;

    int m_sel [c_NP];
    int g_pad = 0;
    bit g_on  = 1'b0;

    pad_func_ctrl_cfg_if #(.PAD_W(5), .FUNC_W(2)) cfg_bus ();

    pad_func_ctrl #(
        .NUM_PADS    (c_NP),
        .NUM_FUNCS   (c_NF),
        .GUARD_CYCLES(c_G)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .cfg      (cfg_bus.slave),
        .func_o_i (func_o),
        .func_oe_i(func_oe),
        .func_i_o (func_i),
        .pad_o_o  (pad_o),
        .pad_oe_o (pad_oe),
        .pad_i_i  (pad_i),
        .sel_o    (sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  pad;
        logic [1:0]  func;
        logic [23:0] pin;
        bit          err;
        bit          guard;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_oe();
        logic [23:0] r = '0;
        for (int p = 0; p < c_NP; p++)
            if (!(g_on && g_pad == p) && m_sel[p] != c_NF - 1)
                r[p] = func_oe[m_sel[p]*c_NP+p];
        return r;
    endfunction

    function automatic logic [23:0] exp_o();
        logic [23:0] r = '0;
        for (int p = 0; p < c_NP; p++)
            if (!(g_on && g_pad == p) && m_sel[p] != c_NF - 1)
                r[p] = func_o[m_sel[p]*c_NP+p];
        return r;
    endfunction

    function automatic logic [95:0] exp_fi();
        logic [95:0] r = '0;
        for (int p = 0; p < c_NP; p++)
            r[m_sel[p]*c_NP+p] = pad_i[p];
        return r;
    endfunction

    function automatic logic [47:0] exp_sel();
        logic [47:0] r = '0;
        for (int p = 0; p < c_NP; p++)
            r[p*2 +: 2] = 2'(m_sel[p]);
        return r;
    endfunction

    task automatic chk_all(input string tag);
        chk({tag, ".sel_o"},    128'(sel),    128'(exp_sel()));
        chk({tag, ".pad_oe_o"}, 128'(pad_oe), 128'(exp_oe()));
        chk({tag, ".pad_o_o"},  128'(pad_o),  128'(exp_o()));
        chk({tag, ".func_i_o"}, 128'(func_i), 128'(exp_fi()));
    endtask

    task automatic clear_model();
        for (int p = 0; p < c_NP; p++) m_sel[p] = 0;
        g_on = 1'b0;
    endtask

    // One request from an idle controller, following it through to its done pulse.
    task automatic do_req(input logic [4:0] pad, input logic [1:0] func,
                          input logic [23:0] pin, input bit err, input bit guard);
        pad_i = pin;
        cfg_bus.cfg_valid_i = 1'b1;
        cfg_bus.cfg_pad_i   = pad;
        cfg_bus.cfg_func_i  = func;
        chk("req.ready_before", 128'(cfg_bus.cfg_ready_o), 128'(1));
        tick();
        cfg_bus.cfg_valid_i = 1'b0;
        if (guard) begin
            g_on  = 1'b1;
            g_pad = int'(pad);
            for (int k = 0; k < c_G; k++) begin
                chk("guard.ready", 128'(cfg_bus.cfg_ready_o), 128'(0));
                chk("guard.done",  128'(cfg_bus.cfg_done_o),  128'(0));
                chk_all("guard");
                tick();
            end
            g_on = 1'b0;
            m_sel[pad] = int'(func);
            chk("commit.done",  128'(cfg_bus.cfg_done_o),  128'(1));
            chk("commit.err",   128'(cfg_bus.cfg_err_o),   128'(0));
            chk("commit.ready", 128'(cfg_bus.cfg_ready_o), 128'(1));
            chk_all("commit");
        end else begin
            chk("quick.done",  128'(cfg_bus.cfg_done_o),  128'(1));
            chk("quick.err",   128'(cfg_bus.cfg_err_o),   128'(err));
            chk("quick.ready", 128'(cfg_bus.cfg_ready_o), 128'(1));
            chk_all("quick");
        end
        tick();
        chk("pulse.done_low", 128'(cfg_bus.cfg_done_o), 128'(0));
        chk("pulse.err_low",  128'(cfg_bus.cfg_err_o),  128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{pad: 5'd5,  func: 2'd1, pin: 24'h00_0020, err: 1'b0, guard: 1'b1};
        vecs[1] = '{pad: 5'd7,  func: 2'd0, pin: 24'h5A_5A5A, err: 1'b0, guard: 1'b0};
        vecs[2] = '{pad: 5'd24, func: 2'd0, pin: 24'hA5_A5A5, err: 1'b1, guard: 1'b0};
        vecs[3] = '{pad: 5'd31, func: 2'd2, pin: 24'hFF_00FF, err: 1'b1, guard: 1'b0};
        vecs[4] = '{pad: 5'd5,  func: 2'd1, pin: 24'h12_3456, err: 1'b0, guard: 1'b0};
        vecs[5] = '{pad: 5'd10, func: 2'd2, pin: 24'hFF_FBFF, err: 1'b0, guard: 1'b1};
        vecs[6] = '{pad: 5'd10, func: 2'd0, pin: 24'h00_0400, err: 1'b0, guard: 1'b1};
        vecs[7] = '{pad: 5'd0,  func: 2'd3, pin: 24'hFF_FFFF, err: 1'b0, guard: 1'b1};
        vecs[8] = '{pad: 5'd23, func: 2'd1, pin: 24'h80_0001, err: 1'b0, guard: 1'b1};

        // Slot 0 drives o=1, slot 1 o=0, slot 2 a pattern with patterned oe,
        // slot 3 (parked) tries to drive but must never reach a pad.
        func_o  = {24'hFFFFFF, 24'hA5A5A5, 24'h000000, 24'hFFFFFF};
        func_oe = {24'hFFFFFF, 24'h0F0F0F, 24'hFFFFFF, 24'hFFFFFF};
        pad_i   = 24'h3C3C3C;
        cfg_bus.cfg_valid_i = 1'b0;
        cfg_bus.cfg_pad_i   = '0;
        cfg_bus.cfg_func_i  = '0;
        clear_model();

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        chk("reset.sel_o",    128'(sel),                 128'(0));
        chk("reset.pad_oe_o", 128'(pad_oe),              128'(24'hFFFFFF));
        chk("reset.ready",    128'(cfg_bus.cfg_ready_o), 128'(1));
        chk("reset.done",     128'(cfg_bus.cfg_done_o),  128'(0));
        rst = 1'b0;
        chk_all("reset");

        // Table-driven single requests.
        for (int i = 0; i < 9; i++)
            do_req(vecs[i].pad, vecs[i].func, vecs[i].pin, vecs[i].err, vecs[i].guard);

        // Valid held through a guard: pad 5 -> 2, then pad 3 -> parked.
        pad_i = 24'h0F0F28;
        cfg_bus.cfg_valid_i = 1'b1;
        cfg_bus.cfg_pad_i   = 5'd5;
        cfg_bus.cfg_func_i  = 2'd2;
        tick();
        cfg_bus.cfg_pad_i  = 5'd3;
        cfg_bus.cfg_func_i = 2'd3;
        g_on  = 1'b1;
        g_pad = 5;
        for (int k = 0; k < c_G; k++) begin
            chk("hold.ready", 128'(cfg_bus.cfg_ready_o), 128'(0));
            chk_all("hold.guard5");
            tick();
        end
        g_on = 1'b0;
        m_sel[5] = 2;
        chk("hold.done5", 128'(cfg_bus.cfg_done_o),  128'(1));
        chk("hold.ready5", 128'(cfg_bus.cfg_ready_o), 128'(1));
        chk_all("hold.commit5");
        tick();
        cfg_bus.cfg_valid_i = 1'b0;
        g_on  = 1'b1;
        g_pad = 3;
        for (int k = 0; k < c_G; k++) begin
            chk("hold.done3_low", 128'(cfg_bus.cfg_done_o),  128'(0));
            chk("hold.ready3",    128'(cfg_bus.cfg_ready_o), 128'(0));
            chk_all("hold.guard3");
            tick();
        end
        g_on = 1'b0;
        m_sel[3] = 3;
        chk("hold.done3", 128'(cfg_bus.cfg_done_o), 128'(1));
        chk_all("hold.commit3");
        tick();
        chk("hold.parked_oe3", 128'(pad_oe[3]), 128'(0));
        chk_all("hold.after");

        // Back-to-back quick requests: error then same-function.
        cfg_bus.cfg_valid_i = 1'b1;
        cfg_bus.cfg_pad_i   = 5'd24;
        cfg_bus.cfg_func_i  = 2'd0;
        tick();
        cfg_bus.cfg_pad_i = 5'd7;
        chk("b2b.done1", 128'(cfg_bus.cfg_done_o), 128'(1));
        chk("b2b.err1",  128'(cfg_bus.cfg_err_o),  128'(1));
        chk("b2b.ready", 128'(cfg_bus.cfg_ready_o), 128'(1));
        tick();
        cfg_bus.cfg_valid_i = 1'b0;
        chk("b2b.done2", 128'(cfg_bus.cfg_done_o), 128'(1));
        chk("b2b.err2",  128'(cfg_bus.cfg_err_o),  128'(0));
        tick();
        chk("b2b.done_low", 128'(cfg_bus.cfg_done_o), 128'(0));
        chk_all("b2b");

        // Reset in the second guard cycle of pad 5 (2 -> 1).
        cfg_bus.cfg_valid_i = 1'b1;
        cfg_bus.cfg_pad_i   = 5'd5;
        cfg_bus.cfg_func_i  = 2'd1;
        tick();
        cfg_bus.cfg_valid_i = 1'b0;
        g_on  = 1'b1;
        g_pad = 5;
        chk_all("rstg.guard1");
        tick();
        chk_all("rstg.guard2");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        chk("rstg.ready", 128'(cfg_bus.cfg_ready_o), 128'(1));
        chk("rstg.done",  128'(cfg_bus.cfg_done_o),  128'(0));
        chk("rstg.err",   128'(cfg_bus.cfg_err_o),   128'(0));
        chk_all("rstg.after");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rstg.no_done", 128'(cfg_bus.cfg_done_o), 128'(0));
            chk_all("rstg.later");
        end

        // Reset wins over a transfer on the same edge.
        do_req(5'd9, 2'd2, 24'h00_0200, 1'b0, 1'b1);
        cfg_bus.cfg_valid_i = 1'b1;
        cfg_bus.cfg_pad_i   = 5'd9;
        cfg_bus.cfg_func_i  = 2'd1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cfg_bus.cfg_valid_i = 1'b0;
        clear_model();
        chk("rstx.ready", 128'(cfg_bus.cfg_ready_o), 128'(1));
        chk("rstx.done",  128'(cfg_bus.cfg_done_o),  128'(0));
        chk_all("rstx");
        tick();
        chk("rstx.ready2", 128'(cfg_bus.cfg_ready_o), 128'(1));
        chk("rstx.done2",  128'(cfg_bus.cfg_done_o),  128'(0));
        chk_all("rstx2");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pad_func_ctrl.md
# pad_func_ctrl

Pad function controller between the SoC peripherals and the chip IO pad ring. It time-shares each bidirectional pad between several peripheral functions (GPIO, pulser, advanced timer, parked) and accepts reconfiguration requests over a valid/ready port. On every function change it applies a break-before-make guard interval, so no two drivers ever contend on a pad. It sits between `croc_soc` peripheral outputs and the `sg13g2_IOPadInOut30mA` `c2p`/`c2p_en`/`p2c` pins.

## Interface
- `NumPads`, 24: number of managed bidirectional pads.
- `NumFuncs`, 4: function slots per pad. Slot 0 = GPIO, 1 = pulser, 2 = timer, `NumFuncs-1` = parked (never drives).
- `GuardCycles`, 4: forced-off cycles on a function change. Must be ≥ 1.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `cfg_valid_i`  in  1  reconfiguration request valid.
- `cfg_ready_o`  out  1  controller can accept a request.
- `cfg_pad_i`  in  `$clog2(NumPads)`  target pad index.
- `cfg_func_i`  in  `$clog2(NumFuncs)`  requested function slot.
- `cfg_done_o`  out  1  one-cycle pulse marking request completion.
- `cfg_err_o`  out  1  qualifies `cfg_done_o` as a rejected request.
- `func_o_i`  in  `NumFuncs*NumPads`  per-function output data; bit `f*NumPads+p`.
- `func_oe_i`  in  `NumFuncs*NumPads`  per-function output enables; same layout.
- `func_i_o`  out  `NumFuncs*NumPads`  pad input routed to each function.
- `pad_o_o`  out  `NumPads`  to pad `c2p`.
- `pad_oe_o`  out  `NumPads`  to pad `c2p_en`.
- `pad_i_i`  in  `NumPads`  from pad `p2c`.
- `sel_o`  out  `NumPads*$clog2(NumFuncs)`  current per-pad function selection.

## Operation
- Registered state: per-pad `sel[p]`; FSM with states IDLE and GUARD; registered `tgt_pad`, `tgt_func` and guard counter `cnt`; registered `cfg_done_o` and `cfg_err_o`.
- Output mux, combinational: for a pad `p` that is not guarded, `pad_o_o[p]` and `pad_oe_o[p]` equal `func_o_i`/`func_oe_i` of slot `sel[p]`. When `sel[p] == NumFuncs-1`, both outputs are 0.
- Guarded pad: `p == tgt_pad` while in GUARD. `pad_o_o[p] = 0` and `pad_oe_o[p] = 0`.
- Input routing: `func_i_o[f*NumPads+p] = pad_i_i[p]` if `sel[p] == f`, else 0. Inputs follow the old `sel` until commit.
- `cfg_ready_o = (state == IDLE)`. A transfer occurs on a clock edge where `cfg_valid_i && cfg_ready_o`.
- IDLE, on transfer:
  - `cfg_pad_i >= NumPads` or `cfg_func_i >= NumFuncs`: no state change. Next cycle `cfg_done_o = cfg_err_o = 1`.
  - `cfg_func_i == sel[cfg_pad_i]`: no guard. Next cycle `cfg_done_o = 1`, `cfg_err_o = 0`.
  - Otherwise: latch `tgt_pad` and `tgt_func`, set `cnt = GuardCycles-1`, go to GUARD.
- GUARD:
  - Each edge with `cnt != 0`: decrement `cnt`.
  - Edge with `cnt == 0`: `sel[tgt_pad] <= tgt_func`, go to IDLE, `cfg_done_o <= 1`.
  - `cfg_valid_i` is ignored in GUARD. The requester holds its request until `cfg_ready_o` is high.
- `cfg_done_o` and `cfg_err_o` are high for exactly one cycle. `cfg_err_o` is never high without `cfg_done_o`.
- Only one pad is ever in reconfiguration; all other pads keep passing traffic unaffected.

## Timing
- Reset values: all `sel[p] = 0` (GPIO), state IDLE, `cfg_ready_o = 1`, `cfg_done_o = 0`, `cfg_err_o = 0`, `cnt = 0`.
- `pad_o_o`/`pad_oe_o` follow `func_*_i` and `sel` combinationally. `sel_o` reflects the registers.
- Function change: transfer at edge E0 → target pad forced off during cycles E0..E0+`GuardCycles` → commit at edge E0+`GuardCycles`.
  - In the cycle after the commit edge, the new function drives, `cfg_done_o = 1` and `cfg_ready_o = 1`.
  - The next transfer is possible at edge E0+`GuardCycles`+1.
- Same-function and error requests: `cfg_done_o` high in the cycle after E0. `cfg_ready_o` stays high, so back-to-back transfers are allowed.
- Reset during GUARD: the next cycle shows reset values. The pending change is discarded with no `cfg_done_o`, and the target pad returns to GPIO.
- Reset has priority over a transfer on the same edge.

## Test plan
- Reset: assert `rst_i` for 2 cycles with `func_oe_i` slot 0 = all ones → `sel_o = 0`, `pad_oe_o = 24'hFFFFFF`, `cfg_ready_o = 1`, no done.
- Switch pad 5 to func 1 (`GuardCycles = 4`), with slot 0 driving oe=1/o=1 and slot 1 driving oe=1/o=0 →
  - `pad_oe_o[5] = 0` for exactly 4 cycles, `cfg_ready_o = 0` during that window.
  - Then `pad_oe_o[5] = 1` and `pad_o_o[5] = 0` together with a single `cfg_done_o` pulse.
  - `func_i_o` bit `1*24+5` now tracks `pad_i_i[5]`. Other pads are unchanged throughout.
- Request pad 7 func 0 while it is already 0 → `cfg_done_o = 1` one cycle later, `cfg_err_o = 0`, no guard window.
- Request pad 24 → `cfg_done_o = cfg_err_o = 1` one cycle later; `sel_o` unchanged.
- Hold `cfg_valid_i` high with a second request (pad 3 → func 3) during the pad 5 guard → second transfer accepted at the edge after the done pulse. Pad 3 then guards for 4 cycles and ends parked (`pad_oe_o[3] = 0` permanently).
- Assert `rst_i` in the 2nd guard cycle of pad 5 → next cycle `sel[5] = 0`, IDLE, no `cfg_done_o`, and `pad_oe_o[5]` follows slot 0 again.
